// File: rtl/key_pio_pkg.sv
// Shared constants for the push-button PIO controller: register map and
// debounce counter width.
package key_pio_pkg;

   localparam int unsigned       DEB_W         = 16;
   localparam logic [DEB_W-1:0]  DEB_DEFAULT_C = 16'd50000;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_DEBOUNCE = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

endpackage

// File: rtl/key_pio_irq_ctrl_debounce_bit.sv
// Single-key conditioning: 2-flop synchroniser, mismatch counter and
// debounced level. The fall (and, with KEY_PIO_IRQ_CTRL_ANY_EDGE_EN, rise)
// pulse is high in the cycle whose closing edge updates stable, so the
// parent captures the edge on the same clock as the level change.
module key_debounce_bit
   import key_pio_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pin,
   input  logic [DEB_W-1:0] deb,
   output logic             stable,
   output logic             fall
`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
   ,
   output logic             rise
`endif
);

   logic             sync1;
   logic             sync2;
   logic [DEB_W-1:0] cnt;
   logic             at_limit;

   assign at_limit = (cnt == deb);
   assign fall     = stable & ~sync2 & at_limit;
`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
   assign rise     = ~stable & sync2 & at_limit;
`endif

   // Two-stage synchroniser; idles released (high).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Count consecutive mismatch cycles; accept the new level once the count
   // reaches deb. A counter above a freshly lowered deb wraps before matching.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= 1'b1;
      end else if (sync2 == stable) begin
         cnt    <= '0;
      end else if (at_limit) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/key_pio_irq_ctrl.sv
// Avalon-MM push-button controller: per-key debounce, press-edge capture
// with W1C clear, maskable registered interrupt, registered read data.
// Build option KEY_PIO_IRQ_CTRL_ANY_EDGE_EN: capture releases as well as
// presses.
module key_pio_irq_ctrl
   import key_pio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [DEB_W-1:0] DEB_DEFAULT = DEB_DEFAULT_C
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] capture;
   logic [DEB_W-1:0] deb;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] w1c;
   logic [31:0]      rd_next;
   logic             wr;
   logic             unused_wd;

   assign wr        = chipselect & ~write_n;
   assign w1c       = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wd = ^writedata[31:DEB_W];

`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
   logic [WIDTH-1:0] rise;
   assign capture = fall | rise;
`else
   assign capture = fall;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      key_debounce_bit u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .pin     (in_port[i]),
         .deb     (deb),
         .stable  (stable[i]),
         .fall    (fall[i])
`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
         ,
         .rise    (rise[i])
`endif
      );
   end

   // Control registers; an edge arriving with a W1C on the same bit wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb     <= DEB_DEFAULT;
         mask    <= '0;
         edgecap <= '0;
      end else begin
         if (wr && address == ADDR_DEBOUNCE) deb  <= writedata[DEB_W-1:0];
         if (wr && address == ADDR_IRQMASK)  mask <= writedata[WIDTH-1:0];
         edgecap <= (edgecap & ~w1c) | capture;
      end
   end

   // Read mux; DATA is inverted so a pressed key reads as 1.
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:     rd_next[WIDTH-1:0] = ~stable;
         ADDR_DEBOUNCE: rd_next[DEB_W-1:0] = deb;
         ADDR_IRQMASK:  rd_next[WIDTH-1:0] = mask;
         ADDR_EDGECAP:  rd_next[WIDTH-1:0] = edgecap;
         default:       rd_next = '0;
      endcase
   end

   // Registered read data and interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_next;
         irq      <= |(edgecap & mask);
      end
   end

endmodule

// File: tb/tb_key_pio_irq_ctrl.sv
// Bench for key_pio_irq_ctrl: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a behavioural model that decides the
// debounced level from a window of past pin samples.
module tb_key_pio_irq_ctrl;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = 2'd0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port = '1;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [W-1:0]  m_stable;
   logic [W-1:0]  m_ec;
   logic [W-1:0]  m_mask;
   logic [15:0]   m_deb;
   logic          m_irq;
   logic [31:0]   m_rd;
   logic [W-1:0]  hist[$];

   always #5 clk = ~clk;

   key_pio_irq_ctrl #(.WIDTH(W), .DEB_DEFAULT(16'd50000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_stable = '1;
      m_ec     = '0;
      m_mask   = '0;
      m_deb    = 16'd50000;
      m_irq    = 1'b0;
      m_rd     = '0;
      hist.delete();
      for (int i = 0; i < 40; i++) hist.push_back('1);
   endfunction

   // One clock: advance the model with the inputs present at this edge,
   // then compare registered outputs just after the edge.
   // A key's debounced level flips when the synchronised samples used at the
   // last m_deb+1 edges (pin values from two edges earlier) all differ from it.
   task automatic step();
      logic [W-1:0] nst, cap, w1c;
      logic [31:0]  rd;
      bit           wr, all_diff;
      @(posedge clk);
      wr = chipselect && !write_n;
      rd = '0;
      case (address)
         2'd0: rd[W-1:0] = ~m_stable;
         2'd1: rd[15:0]  = m_deb;
         2'd2: rd[W-1:0] = m_mask;
         default: rd[W-1:0] = m_ec;
      endcase
      hist.push_back(in_port);
      if (hist.size() > 80) void'(hist.pop_front());
      nst = m_stable;
      cap = '0;
      for (int i = 0; i < W; i++) begin
         if (hist.size() >= int'(m_deb) + 3) begin
            all_diff = 1'b1;
            for (int k = 0; k <= int'(m_deb); k++)
               if (hist[hist.size() - 3 - k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) begin
               nst[i] = ~m_stable[i];
`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
               cap[i] = 1'b1;
`else
               cap[i] = m_stable[i];
`endif
            end
         end
      end
      m_irq = |(m_ec & m_mask);
      w1c   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_ec  = (m_ec & ~w1c) | cap;
      if (wr && address == 2'd1) m_deb  = writedata[15:0];
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable = nst;
      m_rd     = rd;
      #1;
      check("readdata", readdata, m_rd);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      step();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
      address = a;
      step();
      check(tag, readdata, exp);
   endtask

   initial begin
      // Reset
      model_reset();
      #2;
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      #10 reset_n = 1'b1;
      rd_reg(2'd1, 32'd50000, "rst_debounce");
      rd_reg(2'd0, 32'd0, "rst_data");
      rd_reg(2'd2, 32'd0, "rst_mask");
      rd_reg(2'd3, 32'd0, "rst_edgecap");

      // Clean press of key0 with DEBOUNCE = 3: stable changes on the 6th edge
      // after the pin change; the registered DATA read shows it one edge later.
      wr_reg(2'd1, 32'd3);
      address = 2'd0;
      in_port = 4'b1110;
      repeat (6) step();
      check("press_data_pre", readdata, 32'h0);
      step();
      check("press_data", readdata, 32'h1);
      rd_reg(2'd3, 32'h1, "press_edgecap");
      check("press_irq_masked", {31'd0, irq}, 32'd0);
      in_port = '1;
      repeat (8) step();
      wr_reg(2'd3, 32'h1);
      rd_reg(2'd3, 32'h0, "press_cleared");

      // Bounce rejection: key1 low for 3 clocks, 5 times
      for (int n = 0; n < 5; n++) begin
         in_port = 4'b1101;
         repeat (3) step();
         in_port = '1;
         repeat (3) step();
      end
      rd_reg(2'd0, 32'h0, "bounce_data");
      rd_reg(2'd3, 32'h0, "bounce_edgecap");

      // IRQ path on key2
      wr_reg(2'd2, 32'h4);
      in_port = 4'b1011;
      repeat (6) step();
      check("irq_pre", {31'd0, irq}, 32'd0);
      step();
      check("irq_set", {31'd0, irq}, 32'd1);
      in_port = '1;
      repeat (8) step();
      wr_reg(2'd3, 32'h4);
      step();
      check("irq_clr", {31'd0, irq}, 32'd0);
      rd_reg(2'd3, 32'h0, "irq_edgecap_clr");

      // Set/clear collision on key0: the press edge lands on the 6th edge
      in_port = 4'b1110;
      repeat (5) step();
      wr_reg(2'd3, 32'h1);
      rd_reg(2'd3, 32'h1, "collision");
      in_port = '1;
      repeat (8) step();
      wr_reg(2'd3, 32'hF);
      rd_reg(2'd3, 32'h0, "collision_clr");

      // Press/release key3 with DEBOUNCE = 0
      wr_reg(2'd1, 32'd0);
      in_port = 4'b0111;
      repeat (4) step();
      rd_reg(2'd3, 32'h8, "edge_press");
      wr_reg(2'd3, 32'h8);
      in_port = '1;
      repeat (4) step();
`ifdef KEY_PIO_IRQ_CTRL_ANY_EDGE_EN
      rd_reg(2'd3, 32'h8, "edge_release");
`else
      rd_reg(2'd3, 32'h0, "edge_release");
`endif

      // Randomized phase, DEBOUNCE fixed while running
      wr_reg(2'd1, 32'd2);
      wr_reg(2'd2, $urandom_range(15, 0));
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(5, 0) == 0) in_port[i] = ~in_port[i];
         address = 2'($urandom_range(3, 0));
         if ($urandom_range(7, 0) == 0) begin
            address    = ($urandom_range(1, 0) == 0) ? 2'd2 : 2'd3;
            chipselect = 1'b1;
            write_n    = 1'b0;
            writedata  = $urandom();
         end else begin
            chipselect = $urandom_range(1, 0) == 1;
            write_n    = 1'b1;
            writedata  = $urandom();
         end
         step();
         chipselect = 1'b0;
         write_n    = 1'b1;
      end

      // Async reset mid-operation
      in_port = 4'b0000;
      repeat (3) step();
      reset_n = 1'b0;
      #1;
      check("rst2_readdata", readdata, 32'd0);
      check("rst2_irq", {31'd0, irq}, 32'd0);
      in_port = '1;
      model_reset();
      #12 reset_n = 1'b1;
      rd_reg(2'd1, 32'd50000, "rst2_debounce");
      rd_reg(2'd3, 32'd0, "rst2_edgecap");
      rd_reg(2'd2, 32'd0, "rst2_mask");
      rd_reg(2'd0, 32'd0, "rst2_data");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
